// File: rtl/ledshift_pkg.sv
// ledshift_pkg: shared FSM state encoding and default sizes for the ledshift run sequencer
package ledshift_pkg;
   typedef enum logic [2:0] {IDLE, START, RUN, STOP, GAP} state_t;
   localparam int RUN_W_DEF    = 16;
   localparam int CNT_W_DEF    = 8;
   localparam int HOLD_CYC_DEF = 2;
   localparam int GAP_CYC_DEF  = 4;
   localparam int DEB_CYC_DEF  = 8;
endpackage

// File: rtl/ledshift_ctrl_btn_debounce.sv
// btn_debounce: raw button to one-cycle request (2-FF sync, optional debounce, rising-edge detect)
// Ports: clk, rst (async active-low), btn (raw async level), req (one-cycle pulse per accepted press)
// Macro LEDSHIFT_CTRL_DEBOUNCE_EN inserts a DEB_CYC-sample debouncer after the synchronizer.
module btn_debounce #(
   parameter int DEB_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic req
);
   logic [1:0] sync;
   logic       lvl, prev;
`ifdef LEDSHIFT_CTRL_DEBOUNCE_EN
   localparam int CW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
   logic [CW-1:0] cnt;
   // lvl flips only after DEB_CYC consecutive samples that disagree with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl <= 1'b0;
         cnt <= '0;
      end else if (sync[1] == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
         lvl <= sync[1];
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   logic unused_deb;
   assign unused_deb = DEB_CYC != 0;
   assign lvl = sync[1];
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         prev <= lvl;
      end
   end
   assign req = lvl & ~prev;
endmodule

// File: rtl/ledshift_ctrl.sv
// ledshift_ctrl: run sequencer arbitrating button/host requests into timed i_start/i_stop runs
// Ports: clk, rst (async active-low); i_btn_start/i_btn_stop raw buttons; i_host_start/i_host_stop
//   sync pulses; i_run_len cycles per run (0 -> 1); i_runs run count (0 = continuous);
//   o_start one-cycle pulse, o_stop hold, o_busy (not IDLE), o_runs_done saturating run count.
// Macro LEDSHIFT_CTRL_DEBOUNCE_EN enables button debouncing (DEB_CYC samples).
module ledshift_ctrl
   import ledshift_pkg::*;
#(
   parameter int RUN_W    = RUN_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int HOLD_CYC = HOLD_CYC_DEF,
   parameter int GAP_CYC  = GAP_CYC_DEF,
   parameter int DEB_CYC  = DEB_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_btn_start,
   input  logic             i_btn_stop,
   input  logic             i_host_start,
   input  logic             i_host_stop,
   input  logic [RUN_W-1:0] i_run_len,
   input  logic [CNT_W-1:0] i_runs,
   output logic             o_start,
   output logic             o_stop,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_runs_done
);
   logic             btn_start_req, btn_stop_req;
   logic             start_req, stop_req, start_ok, last;
   state_t           state, state_n;
   logic [RUN_W-1:0] timer, len;
   logic [CNT_W-1:0] runs_left;
   logic             cont, abort;
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn_start (.clk(clk), .rst(rst), .btn(i_btn_start), .req(btn_start_req));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn_stop  (.clk(clk), .rst(rst), .btn(i_btn_stop),  .req(btn_stop_req));
   assign start_req = i_host_start | btn_start_req;
   assign stop_req  = i_host_stop | btn_stop_req;
   assign start_ok  = start_req & ~stop_req;
   // one timer serves RUN, STOP hold and GAP; each phase ends when it reads 1
   assign last      = timer == RUN_W'(1);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start_ok ? START : IDLE;
         START:   state_n = stop_req ? STOP : RUN;
         RUN:     state_n = (stop_req || last) ? STOP : RUN;
         STOP:    state_n = !last ? STOP : (abort || (!cont && runs_left == CNT_W'(1))) ? IDLE : GAP;
         GAP:     state_n = stop_req ? STOP : last ? START : GAP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         timer       <= '0;
         len         <= '0;
         runs_left   <= '0;
         cont        <= 1'b0;
         abort       <= 1'b0;
         o_start     <= 1'b0;
         o_stop      <= 1'b0;
         o_busy      <= 1'b0;
         o_runs_done <= '0;
      end else begin
         state   <= state_n;
         o_start <= state_n == START;
         o_stop  <= state_n == STOP;
         o_busy  <= state_n != IDLE;
         if (state_n == STOP && state != STOP)
            timer <= RUN_W'(HOLD_CYC);
         else if (state_n == GAP && state != GAP)
            timer <= RUN_W'(GAP_CYC);
         else if (state == START)
            timer <= len;
         else if (state != IDLE)
            timer <= timer - 1'b1;
         if (state == IDLE && start_ok) begin
            len         <= i_run_len == '0 ? RUN_W'(1) : i_run_len;
            runs_left   <= i_runs;
            cont        <= i_runs == '0;
            abort       <= 1'b0;
            o_runs_done <= '0;
         end
         if (stop_req && (state == START || state == RUN || state == GAP))
            abort <= 1'b1;
         if (state == STOP && last && !abort) begin
            runs_left <= runs_left - 1'b1;
            if (o_runs_done != '1)
               o_runs_done <= o_runs_done + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ledshift_ctrl.sv
// tb_ledshift_ctrl: directed self-checking bench for ledshift_ctrl (vector table plus corner sequences)
module tb_ledshift_ctrl;
   logic        clk = 1'b0, rst = 1'b0;
   logic        btn_start = 1'b0, btn_stop = 1'b0, host_start = 1'b0, host_stop = 1'b0;
   logic [15:0] run_len = 16'd1;
   logic [7:0]  runs = 8'd1;
   logic        o_start, o_stop, o_busy;
   logic [7:0]  o_runs_done;
   int          checks = 0, failures = 0;
   int          st[$], sp[$];
`ifdef LEDSHIFT_CTRL_DEBOUNCE_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 3;
`endif
   typedef struct {
      logic        hs, hp;
      logic [15:0] len;
      logic        e_start, e_stop, e_busy;
      logic [7:0]  e_done;
   } vec_t;
   vec_t vt[17];
   ledshift_ctrl dut (
      .clk(clk), .rst(rst),
      .i_btn_start(btn_start), .i_btn_stop(btn_stop),
      .i_host_start(host_start), .i_host_stop(host_stop),
      .i_run_len(run_len), .i_runs(runs),
      .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy), .o_runs_done(o_runs_done)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic host_go(input logic [15:0] l, input logic [7:0] r);
      run_len = l;
      runs = r;
      host_start = 1'b1;
      step();
      host_start = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      while (o_busy && n < 200) begin
         step();
         n++;
      end
      check(name, o_busy, 0);
   endtask
   initial begin
      int first, n, bad, last_t;
      bit found;
      vt[0]  = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 8'd0};
      vt[1]  = '{1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 8'd0};
      vt[2]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1, 8'd0};
      vt[3]  = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1, 8'd0};
      vt[4]  = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[5]  = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[6]  = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 8'd1};
      vt[7]  = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 8'd1};
      vt[8]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1, 8'd0};
      vt[9]  = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[10] = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[11] = '{1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 8'd0};
      vt[12] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 8'd0};
      vt[13] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'd0};
      vt[14] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 8'd0};
      vt[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd1};
      step();
      step();
      rst = 1'b1;
      check("reset_start", o_start, 0);
      check("reset_busy", o_busy, 0);
      // per-cycle vectors: single run, simultaneous start/stop, abort in START, run_len 0
      runs = 8'd1;
      for (int i = 0; i < 17; i++) begin
         host_start = vt[i].hs;
         host_stop  = vt[i].hp;
         run_len    = vt[i].len;
         step();
         check($sformatf("vec%0d_start", i), o_start, vt[i].e_start);
         check($sformatf("vec%0d_stop", i), o_stop, vt[i].e_stop);
         check($sformatf("vec%0d_busy", i), o_busy, vt[i].e_busy);
         check($sformatf("vec%0d_done", i), o_runs_done, vt[i].e_done);
      end
      host_start = 1'b0;
      host_stop = 1'b0;
      step();
      // three counted runs of length 5: period 1+5+2+4
      host_go(16'd5, 8'd3);
      st.delete();
      sp.delete();
      first = -1;
      for (int i = 0; i < 60; i++) begin
         if (o_start) st.push_back(i);
         if (o_stop) sp.push_back(i);
         if (i == 8) first = o_runs_done;
         step();
      end
      check("cnt_starts", st.size(), 3);
      check("cnt_stops", sp.size(), 6);
      check("cnt_done_after_first", first, 1);
      if (st.size() == 3 && sp.size() == 6) begin
         check("cnt_period1", st[1] - st[0], 12);
         check("cnt_period2", st[2] - st[1], 12);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("cnt_stop_a%0d", k), sp[2*k] - st[k], 6);
            check($sformatf("cnt_stop_b%0d", k), sp[2*k+1] - st[k], 7);
         end
      end
      check("cnt_done", o_runs_done, 3);
      check("cnt_busy", o_busy, 0);
      // host abort 10 cycles after o_start
      host_go(16'd100, 8'd1);
      check("abort_start", o_start, 1);
      for (int i = 0; i < 10; i++) step();
      check("abort_pre_stop", o_stop, 0);
      host_stop = 1'b1;
      step();
      host_stop = 1'b0;
      check("abort_stop1", o_stop, 1);
      step();
      check("abort_stop2", o_stop, 1);
      step();
      check("abort_stop_end", o_stop, 0);
      check("abort_busy", o_busy, 0);
      check("abort_done", o_runs_done, 0);
      // button start while running is ignored
      host_go(16'd100, 8'd1);
      n = 0;
      btn_start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 20) btn_start = 1'b0;
         step();
         if (o_start) n++;
      end
      check("run_btn_start_ignored", n, 0);
      host_stop = 1'b1;
      step();
      host_stop = 1'b0;
      wait_idle("run_btn_idle");
      for (int i = 0; i < 20; i++) step();
      // button stop latency during a run
      host_go(16'd100, 8'd1);
      step();
      first = -1;
      btn_stop = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (o_stop && first < 0) first = i + 1;
      end
      btn_stop = 1'b0;
      check("btn_stop_latency", first, LAT);
      wait_idle("btn_stop_idle");
      for (int i = 0; i < 20; i++) step();
      // bouncing start button, then held high
      run_len = 16'd1;
      runs = 8'd1;
      st.delete();
      for (int i = 0; i < 60; i++) begin
         btn_start = (i < 30) ? ((i / 3) % 2 == 0) : 1'b1;
         step();
         if (o_start) st.push_back(i + 1);
      end
      btn_start = 1'b0;
`ifdef LEDSHIFT_CTRL_DEBOUNCE_EN
      check("bounce_count", st.size(), 1);
      if (st.size() == 1) check("bounce_time", st[0], 41);
`else
      check("bounce_count", st.size(), 6);
      if (st.size() == 6)
         for (int k = 0; k < 6; k++) check($sformatf("bounce_time%0d", k), st[k], 3 + 6 * k);
`endif
      for (int i = 0; i < 20; i++) step();
      wait_idle("bounce_idle");
      // continuous mode, run_len 1: period 1+1+2+4, saturating count
      host_go(16'd1, 8'd0);
      n = 0;
      bad = 0;
      last_t = 0;
      for (int i = 0; i < 3000 && n < 300; i++) begin
         if (o_start) begin
            if (n > 0 && i - last_t != 8) bad++;
            last_t = i;
            n++;
         end
         if (n < 300) step();
      end
      check("cont_runs", n, 300);
      check("cont_period_errors", bad, 0);
      check("cont_saturated", o_runs_done, 255);
      host_stop = 1'b1;
      step();
      host_stop = 1'b0;
      check("cont_stop", o_stop, 1);
      wait_idle("cont_idle");
      check("cont_done_final", o_runs_done, 255);
      // reset during the second run's stop hold
      host_go(16'd3, 8'd2);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (o_stop && o_runs_done == 8'd1) found = 1'b1;
         else step();
      end
      check("rst_found_stop", found, 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_stop", o_stop, 0);
      check("rst_async_busy", o_busy, 0);
      check("rst_async_done", o_runs_done, 0);
      step();
      #2 rst = 1'b1;
      step();
      check("rst_after_busy", o_busy, 0);
      check("rst_after_done", o_runs_done, 0);
      for (int i = 0; i < 5; i++) step();
      check("rst_still_idle", o_busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
